// File: rtl/ajuste_hora.sv
// Time-setting FSM: edits a BCD hh:mm:ss copy and strobes it back to the
// time-keeper on commit, or drops it on reset or inactivity timeout.
module ajuste_hora #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_set,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [7:0] hh_in,
    input  logic [7:0] mm_in,
    input  logic [7:0] ss_in,
    output logic [7:0] hh_out,
    output logic [7:0] mm_out,
    output logic [7:0] ss_out,
    output logic [1:0] campo,
    output logic       editando,
    output logic       wr_stb
);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t      state, state_nx;
    logic [7:0]  hh_nx, mm_nx, ss_nx;
    logic [1:0]  campo_nx;
    logic [15:0] cnt, cnt_nx;
    logic        editando_nx, wr_nx;
    logic        any_btn;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input logic [7:0] max);
        if (v == 8'h00)
            return max;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Out-of-range or non-BCD input starts the edit from zero.
    function automatic logic [7:0] sanitize(input logic [7:0] v,
                                            input logic [7:0] max);
        if (v[3:0] > 4'd9 || v > max)
            return 8'h00;
        return v;
    endfunction

    assign any_btn = btn_set | btn_up | btn_down | btn_left | btn_right;

    always_comb begin
        state_nx = state;
        hh_nx    = hh_out;
        mm_nx    = mm_out;
        ss_nx    = ss_out;
        campo_nx = campo;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (btn_set) begin
                    state_nx = EDIT;
                    hh_nx    = sanitize(hh_in, 8'h23);
                    mm_nx    = sanitize(mm_in, 8'h59);
                    ss_nx    = sanitize(ss_in, 8'h59);
                    campo_nx = 2'd2;
                    cnt_nx   = 16'd0;
                end
            end
            EDIT: begin
                if (btn_set) begin
                    state_nx = COMMIT;
                    cnt_nx   = 16'd0;
                end else begin
                    if (any_btn) begin
                        cnt_nx = 16'd0;
                    end else if (cnt == TIMEOUT - 16'd1) begin
                        state_nx = IDLE;
                        cnt_nx   = 16'd0;
                    end else begin
                        cnt_nx = cnt + 16'd1;
                    end
                    // Value change targets the field selected before the move.
                    if (btn_up ^ btn_down) begin
                        case (campo)
                            2'd0: ss_nx = btn_up ? bcd_inc(ss_out, 8'h59)
                                                 : bcd_dec(ss_out, 8'h59);
                            2'd1: mm_nx = btn_up ? bcd_inc(mm_out, 8'h59)
                                                 : bcd_dec(mm_out, 8'h59);
                            default: hh_nx = btn_up ? bcd_inc(hh_out, 8'h23)
                                                    : bcd_dec(hh_out, 8'h23);
                        endcase
                    end
                    if (btn_left ^ btn_right) begin
                        if (btn_left)
                            campo_nx = (campo == 2'd2) ? 2'd0 : campo + 2'd1;
                        else
                            campo_nx = (campo == 2'd0) ? 2'd2 : campo - 2'd1;
                    end
                end
            end
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        editando_nx = (state_nx == EDIT);
        wr_nx       = (state_nx == COMMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            hh_out   <= 8'h00;
            mm_out   <= 8'h00;
            ss_out   <= 8'h00;
            campo    <= 2'd0;
            cnt      <= 16'd0;
            editando <= 1'b0;
            wr_stb   <= 1'b0;
        end else begin
            state    <= state_nx;
            hh_out   <= hh_nx;
            mm_out   <= mm_nx;
            ss_out   <= ss_nx;
            campo    <= campo_nx;
            cnt      <= cnt_nx;
            editando <= editando_nx;
            wr_stb   <= wr_nx;
        end
    end

endmodule

// File: tb/tb_ajuste_hora.sv
// Directed vector bench for ajuste_hora with TIMEOUT=8: edit walk-through,
// wraps, load sanitising, commit strobe, timeout abort and reset abort.
module tb_ajuste_hora;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_set, btn_up, btn_down, btn_left, btn_right;
    logic [7:0] hh_in, mm_in, ss_in;
    logic [7:0] hh_out, mm_out, ss_out;
    logic [1:0] campo;
    logic       editando, wr_stb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ajuste_hora #(.TIMEOUT(16'd8)) dut (
        .clk(clk), .reset(reset),
        .btn_set(btn_set), .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in),
        .hh_out(hh_out), .mm_out(mm_out), .ss_out(ss_out),
        .campo(campo), .editando(editando), .wr_stb(wr_stb)
    );

    // b = {set, up, down, left, right}
    typedef struct {
        logic [4:0] b;
        logic [7:0] hi, mi, si;
        logic [7:0] eh, em, es;
        logic [1:0] ec;
        logic       ee, ew;
    } vec_t;

    vec_t tv[$];

    localparam logic [4:0] N = 5'b00000;
    localparam logic [4:0] S = 5'b10000;
    localparam logic [4:0] U = 5'b01000;
    localparam logic [4:0] D = 5'b00100;
    localparam logic [4:0] L = 5'b00010;
    localparam logic [4:0] R = 5'b00001;

    task automatic check(input string name, input logic [7:0] eh,
                         input logic [7:0] em, input logic [7:0] es,
                         input logic [1:0] ec, input logic ee,
                         input logic ew);
        checks++;
        if (hh_out !== eh || mm_out !== em || ss_out !== es ||
            campo !== ec || editando !== ee || wr_stb !== ew) begin
            errors++;
            $display("FAIL %s: got %h:%h:%h c=%0d e=%b w=%b, want %h:%h:%h c=%0d e=%b w=%b",
                     name, hh_out, mm_out, ss_out, campo, editando, wr_stb,
                     eh, em, es, ec, ee, ew);
        end
    endtask

    task automatic cyc(input logic [4:0] b, input string name,
                       input logic [7:0] eh, input logic [7:0] em,
                       input logic [7:0] es, input logic [1:0] ec,
                       input logic ee, input logic ew);
        {btn_set, btn_up, btn_down, btn_left, btn_right} = b;
        @(posedge clk);
        #1;
        {btn_set, btn_up, btn_down, btn_left, btn_right} = N;
        check(name, eh, em, es, ec, ee, ew);
    endtask

    initial begin
        tv.push_back('{S,     8'h23,8'h59,8'h58, 8'h23,8'h59,8'h58, 2'd2,1'b1,1'b0});
        tv.push_back('{U,     8'h23,8'h59,8'h58, 8'h00,8'h59,8'h58, 2'd2,1'b1,1'b0});
        tv.push_back('{L,     8'h23,8'h59,8'h58, 8'h00,8'h59,8'h58, 2'd0,1'b1,1'b0});
        tv.push_back('{D,     8'h23,8'h59,8'h58, 8'h00,8'h59,8'h57, 2'd0,1'b1,1'b0});
        tv.push_back('{U|D,   8'h23,8'h59,8'h58, 8'h00,8'h59,8'h57, 2'd0,1'b1,1'b0});
        tv.push_back('{L|R,   8'h23,8'h59,8'h58, 8'h00,8'h59,8'h57, 2'd0,1'b1,1'b0});
        tv.push_back('{R,     8'h23,8'h59,8'h58, 8'h00,8'h59,8'h57, 2'd2,1'b1,1'b0});
        tv.push_back('{D,     8'h23,8'h59,8'h58, 8'h23,8'h59,8'h57, 2'd2,1'b1,1'b0});
        tv.push_back('{D|R,   8'h23,8'h59,8'h58, 8'h22,8'h59,8'h57, 2'd1,1'b1,1'b0});
        tv.push_back('{U,     8'h23,8'h59,8'h58, 8'h22,8'h00,8'h57, 2'd1,1'b1,1'b0});
        tv.push_back('{S|U,   8'h23,8'h59,8'h58, 8'h22,8'h00,8'h57, 2'd1,1'b0,1'b1});
        tv.push_back('{N,     8'h23,8'h59,8'h58, 8'h22,8'h00,8'h57, 2'd1,1'b0,1'b0});
        tv.push_back('{U|L,   8'h23,8'h59,8'h58, 8'h22,8'h00,8'h57, 2'd1,1'b0,1'b0});
        tv.push_back('{S,     8'h00,8'h09,8'h00, 8'h00,8'h09,8'h00, 2'd2,1'b1,1'b0});
        tv.push_back('{R,     8'h00,8'h09,8'h00, 8'h00,8'h09,8'h00, 2'd1,1'b1,1'b0});
        tv.push_back('{U,     8'h00,8'h09,8'h00, 8'h00,8'h10,8'h00, 2'd1,1'b1,1'b0});
        tv.push_back('{U|D,   8'h00,8'h09,8'h00, 8'h00,8'h10,8'h00, 2'd1,1'b1,1'b0});
        tv.push_back('{R,     8'h00,8'h09,8'h00, 8'h00,8'h10,8'h00, 2'd0,1'b1,1'b0});
        tv.push_back('{D,     8'h00,8'h09,8'h00, 8'h00,8'h10,8'h59, 2'd0,1'b1,1'b0});
        tv.push_back('{U,     8'h00,8'h09,8'h00, 8'h00,8'h10,8'h00, 2'd0,1'b1,1'b0});
        tv.push_back('{R,     8'h00,8'h09,8'h00, 8'h00,8'h10,8'h00, 2'd2,1'b1,1'b0});
        tv.push_back('{U,     8'h00,8'h09,8'h00, 8'h01,8'h10,8'h00, 2'd2,1'b1,1'b0});
        tv.push_back('{S,     8'h00,8'h09,8'h00, 8'h01,8'h10,8'h00, 2'd2,1'b0,1'b1});
        tv.push_back('{N,     8'h00,8'h09,8'h00, 8'h01,8'h10,8'h00, 2'd2,1'b0,1'b0});
        tv.push_back('{S,     8'h7A,8'h60,8'h5A, 8'h00,8'h00,8'h00, 2'd2,1'b1,1'b0});
        tv.push_back('{S,     8'h7A,8'h60,8'h5A, 8'h00,8'h00,8'h00, 2'd2,1'b0,1'b1});
        tv.push_back('{N,     8'h7A,8'h60,8'h5A, 8'h00,8'h00,8'h00, 2'd2,1'b0,1'b0});
        tv.push_back('{S,     8'h19,8'h45,8'h30, 8'h19,8'h45,8'h30, 2'd2,1'b1,1'b0});
        tv.push_back('{U,     8'h19,8'h45,8'h30, 8'h20,8'h45,8'h30, 2'd2,1'b1,1'b0});
        tv.push_back('{D,     8'h19,8'h45,8'h30, 8'h19,8'h45,8'h30, 2'd2,1'b1,1'b0});
        tv.push_back('{U,     8'h19,8'h45,8'h30, 8'h20,8'h45,8'h30, 2'd2,1'b1,1'b0});

        reset = 1'b1;
        {btn_set, btn_up, btn_down, btn_left, btn_right} = N;
        hh_in = 8'h12; mm_in = 8'h34; ss_in = 8'h56;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            hh_in = tv[i].hi; mm_in = tv[i].mi; ss_in = tv[i].si;
            cyc(tv[i].b, $sformatf("vec%0d", i), tv[i].eh, tv[i].em,
                tv[i].es, tv[i].ec, tv[i].ee, tv[i].ew);
        end

        // Inactivity: 8 quiet cycles abort the edit without a strobe.
        for (int i = 1; i <= 8; i++)
            cyc(N, $sformatf("tmo%0d", i), 8'h20, 8'h45, 8'h30, 2'd2,
                (i < 8), 1'b0);

        // A pulse at quiet cycle 7 restarts the count.
        cyc(S, "rst_enter", 8'h19, 8'h45, 8'h30, 2'd2, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++)
            cyc(N, $sformatf("pre%0d", i), 8'h19, 8'h45, 8'h30, 2'd2,
                1'b1, 1'b0);
        cyc(L, "pulse7", 8'h19, 8'h45, 8'h30, 2'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++)
            cyc(N, $sformatf("post%0d", i), 8'h19, 8'h45, 8'h30, 2'd0,
                (i < 8), 1'b0);

        // Reset with btn_set high during EDIT.
        cyc(S, "edit_again", 8'h19, 8'h45, 8'h30, 2'd2, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(S, "reset_edit", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(N, "after_reset", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);

        // Reset while in COMMIT.
        cyc(S, "edit3", 8'h19, 8'h45, 8'h30, 2'd2, 1'b1, 1'b0);
        cyc(S, "commit3", 8'h19, 8'h45, 8'h30, 2'd2, 1'b0, 1'b1);
        reset = 1'b1;
        cyc(N, "reset_commit", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc(N, "idle_end", 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ajuste_hora.md
AJUSTE_HORA -- requirements
Module: ajuste_hora

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000: EDIT-state inactivity limit, in clk cycles.
REQ-002 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port btn_set, input, 1: one-cycle debounced pulse from the button input stage; enters or commits edit.
REQ-005 Ports btn_up and btn_down, inputs, 1 each: one-cycle debounced pulses; increment or decrement the selected field.
REQ-006 Ports btn_left and btn_right, inputs, 1 each: one-cycle debounced pulses; move the field cursor.
REQ-007 Ports hh_in, mm_in and ss_in, inputs, 8 each: current time in packed BCD, sampled on edit entry.
REQ-008 Ports hh_out, mm_out and ss_out, outputs, 8 each: working registers in packed BCD.
REQ-009 Port campo, output, 2: selected field (0=ss, 1=mm, 2=hh); value 3 never occurs.
REQ-010 Port editando, output, 1: high while the FSM is in EDIT.
REQ-011 Port wr_stb, output, 1: one-cycle strobe; when high, hh_out, mm_out and ss_out are valid for the time-keeper to load.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, EDIT and COMMIT.
REQ-013 IDLE, btn_set=1 -> EDIT next cycle; same edge: load the working registers from hh_in, mm_in and ss_in, set campo=2, clear the timeout counter.
REQ-014 A loaded field that is non-BCD or above its limit (hh>0x23, mm or ss>0x59) SHALL load as 0x00.
REQ-015 In IDLE, btn_up, btn_down, btn_left and btn_right SHALL be ignored.
REQ-016 EDIT, btn_set=1 -> COMMIT; COMMIT -> IDLE unconditionally after one cycle.
REQ-017 wr_stb SHALL be 1 only during COMMIT; working registers SHALL be unchanged in COMMIT.
REQ-018 btn_up in EDIT SHALL increment the selected field in BCD: units 9 -> 0 with tens+1; ss and mm wrap 0x59 -> 0x00; hh wraps 0x23 -> 0x00.
REQ-019 btn_down in EDIT SHALL decrement the selected field in BCD: units 0 -> 9 with tens-1; ss and mm wrap 0x00 -> 0x59; hh wraps 0x00 -> 0x23.
REQ-020 Increment and decrement SHALL affect only the selected field, with no carry or borrow into neighbouring fields.
REQ-021 btn_up and btn_down in the same cycle SHALL leave the field unchanged.
REQ-022 btn_left SHALL set campo to campo+1 (2 wraps to 0); btn_right SHALL set campo to campo-1 (0 wraps to 2).
REQ-023 btn_left and btn_right in the same cycle SHALL leave campo unchanged.
REQ-024 In one cycle, a value change SHALL apply to the pre-move field and the cursor move SHALL take effect on the same edge.
REQ-025 btn_set in EDIT SHALL take priority: in that cycle, up, down, left and right SHALL be ignored.
REQ-026 The 16-bit timeout counter SHALL clear on any button pulse in EDIT and otherwise increment each EDIT cycle.
REQ-027 When the timeout counter reaches TIMEOUT-1 with no button pulse that cycle: EDIT -> IDLE, no wr_stb (abort), working registers held.
REQ-028 Outputs SHALL be registered; a button pulse at edge N SHALL be visible on the outputs after edge N.
REQ-029 In IDLE, all outputs except wr_stb SHALL hold their last values.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE and set hh_out, mm_out, ss_out, campo, editando, wr_stb and the timeout counter to 0, overriding all other inputs.
REQ-031 Reset in EDIT or COMMIT SHALL abort with no wr_stb in the following cycle.

Verification (TIMEOUT=8)
REQ-032 hh_in=0x23, mm_in=0x59, ss_in=0x58, btn_set, then btn_up -> hh_out=0x00, mm_out=0x59, campo=2.
REQ-033 EDIT, campo=0, ss=0x00, btn_down -> ss=0x59; then btn_right -> campo=2; then btn_down on hh=0x00 -> hh=0x23.
REQ-034 Load mm_in=0x09, btn_right, btn_up -> mm=0x10; btn_up and btn_down together -> mm stays 0x10.
REQ-035 EDIT, btn_set -> wr_stb high exactly 1 cycle with the edited values, editando low the following cycle.
REQ-036 EDIT with no pulses for 8 cycles -> editando falls, wr_stb stays 0; a pulse at cycle 7 restarts the count.
REQ-037 reset mid-EDIT with btn_set high -> all outputs 0, IDLE, no wr_stb; hh_in=0x7A loads as 0x00.
